generador_pulsos: RTL and testbench

GENERADOR_PULSOS -- requirements
Module: generador_pulsos

---
 rtl/generador_pulsos_pkg.sv | 14 +
 rtl/generador_pulsos_temporizador_fase.sv | 27 ++
 rtl/generador_pulsos.sv | 120 ++++++++++++
 tb/tb_generador_pulsos.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/generador_pulsos_pkg.sv
// Shared types and default widths for the pulse-train generator.
package generador_pulsos_pkg;

   localparam int N_W_DEF = 8;
   localparam int T_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ALTO = 2'd1,
      BAJO = 2'd2,
      FIN  = 2'd3
   } estado_t;

endpackage

// File: rtl/generador_pulsos_temporizador_fase.sv
// Phase down-counter: load a duration, expiry flag is high on the phase's last cycle.
module temporizador_fase #(
   parameter int T_W = 16
) (
   input  logic           clk,
   input  logic           rst_i,
   input  logic           carga_i,
   input  logic [T_W-1:0] valor_i,
   output logic           expira_o
);

   logic [T_W-1:0] cuenta;

   // A load value of 0 behaves like 1: the phase lasts a single cycle.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         cuenta <= '0;
      end else if (carga_i) begin
         cuenta <= (valor_i == '0) ? '0 : valor_i - 1'b1;
      end else if (cuenta != '0) begin
         cuenta <= cuenta - 1'b1;
      end
   end

   assign expira_o = (cuenta == '0);

endmodule

// File: rtl/generador_pulsos.sv
// Pulse-train generator: N pulses of t_alto high / t_bajo low cycles, then a fin strobe.
// Optional abort input enabled by defining GENERADOR_PULSOS_ABORT_EN.
module generador_pulsos
   import generador_pulsos_pkg::*;
#(
   parameter int N_W = N_W_DEF,
   parameter int T_W = T_W_DEF
) (
   input  logic           clk,
   input  logic           rst_i,
   input  logic           start_i,
   input  logic [N_W-1:0] num_pulsos_i,
   input  logic [T_W-1:0] t_alto_i,
   input  logic [T_W-1:0] t_bajo_i,
`ifdef GENERADOR_PULSOS_ABORT_EN
   input  logic           abort_i,
`endif
   output logic           pulso_o,
   output logic           ocupado_o,
   output logic           fin_o,
   output logic [N_W-1:0] enviados_o
);

   estado_t        estado, estado_sig;
   logic [N_W-1:0] num_q;
   logic [T_W-1:0] t_alto_q, t_bajo_q;
   logic [N_W-1:0] enviados;
   logic           carga, expira, aceptar, incrementar;
   logic [T_W-1:0] valor_carga;

   temporizador_fase #(.T_W(T_W)) u_temporizador (
      .clk      (clk),
      .rst_i    (rst_i),
      .carga_i  (carga),
      .valor_i  (valor_carga),
      .expira_o (expira)
   );

   // A zero-count train spends one low cycle in BAJO, where the count check
   // sends it straight to FIN without ever raising the pulse.
   always_comb begin
      estado_sig  = estado;
      carga       = 1'b0;
      valor_carga = '0;
      aceptar     = 1'b0;
      incrementar = 1'b0;
      case (estado)
         IDLE: begin
            if (start_i) begin
               aceptar = 1'b1;
               carga   = 1'b1;
               if (num_pulsos_i == '0) begin
                  estado_sig = BAJO;
               end else begin
                  estado_sig  = ALTO;
                  valor_carga = t_alto_i;
               end
            end
         end
         ALTO: begin
            if (expira) begin
               estado_sig  = BAJO;
               carga       = 1'b1;
               valor_carga = t_bajo_q;
               incrementar = 1'b1;
            end
         end
         BAJO: begin
            if (expira) begin
               if (enviados < num_q) begin
                  estado_sig  = ALTO;
                  carga       = 1'b1;
                  valor_carga = t_alto_q;
               end else begin
                  estado_sig = FIN;
               end
            end
         end
         FIN:     estado_sig = IDLE;
         default: estado_sig = IDLE;
      endcase
`ifdef GENERADOR_PULSOS_ABORT_EN
      if (abort_i && ((estado == ALTO) || (estado == BAJO))) begin
         estado_sig  = FIN;
         carga       = 1'b0;
         incrementar = 1'b0;
      end
`endif
   end

   // Outputs are decoded from the next state so they change together with it.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         estado    <= IDLE;
         pulso_o   <= 1'b0;
         ocupado_o <= 1'b0;
         fin_o     <= 1'b0;
         enviados  <= '0;
         num_q     <= '0;
         t_alto_q  <= '0;
         t_bajo_q  <= '0;
      end else begin
         estado    <= estado_sig;
         pulso_o   <= (estado_sig == ALTO);
         ocupado_o <= (estado_sig != IDLE);
         fin_o     <= (estado_sig == FIN);
         if (aceptar) begin
            num_q    <= num_pulsos_i;
            t_alto_q <= t_alto_i;
            t_bajo_q <= t_bajo_i;
            enviados <= '0;
         end else if (incrementar) begin
            enviados <= enviados + 1'b1;
         end
      end
   end

   assign enviados_o = enviados;

endmodule

// File: tb/tb_generador_pulsos.sv
// Self-checking bench for generador_pulsos: per-cycle model comparison plus directed literal checks.
// Define GENERADOR_PULSOS_ABORT_EN to also exercise the abort input.
module tb_generador_pulsos;

   localparam int N_W = 8;
   localparam int T_W = 16;

   typedef struct packed {
      logic           pulso;
      logic           ocup;
      logic           fin;
      logic [N_W-1:0] env;
   } obs_t;

   logic           clk = 1'b0;
   logic           rst_i = 1'b1;
   logic           start_i = 1'b0;
   logic [N_W-1:0] num_pulsos_i = '0;
   logic [T_W-1:0] t_alto_i = '0;
   logic [T_W-1:0] t_bajo_i = '0;
   logic           abort_i = 1'b0;
   logic           pulso_o, ocupado_o, fin_o;
   logic [N_W-1:0] enviados_o;

   int   vectors = 0;
   int   miscompares = 0;
   bit   checkEn = 1'b0;
   obs_t expO = '0;
   obs_t q[$];
   logic [N_W-1:0] lastEnv = '0;

   always #5 clk = ~clk;

   generador_pulsos #(.N_W(N_W), .T_W(T_W)) dut (
      .clk          (clk),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .num_pulsos_i (num_pulsos_i),
      .t_alto_i     (t_alto_i),
      .t_bajo_i     (t_bajo_i),
`ifdef GENERADOR_PULSOS_ABORT_EN
      .abort_i      (abort_i),
`endif
      .pulso_o      (pulso_o),
      .ocupado_o    (ocupado_o),
      .fin_o        (fin_o),
      .enviados_o   (enviados_o)
   );

   function automatic obs_t mk(input logic p, input logic o, input logic f, input logic [N_W-1:0] e);
      obs_t r;
      r.pulso = p;
      r.ocup  = o;
      r.fin   = f;
      r.env   = e;
      return r;
   endfunction

   // The whole expected waveform of an accepted train, one entry per cycle.
   task automatic buildTrain(input logic [N_W-1:0] n, input logic [T_W-1:0] ta, input logic [T_W-1:0] tb);
      int a, b;
      a = (ta == '0) ? 1 : int'(ta);
      b = (tb == '0) ? 1 : int'(tb);
      q.delete();
      if (n == '0) q.push_back(mk(1'b0, 1'b1, 1'b0, '0));
      for (int k = 1; k <= int'(n); k++) begin
         repeat (a) q.push_back(mk(1'b1, 1'b1, 1'b0, N_W'(k - 1)));
         repeat (b) q.push_back(mk(1'b0, 1'b1, 1'b0, N_W'(k)));
      end
      q.push_back(mk(1'b0, 1'b1, 1'b1, n));
      lastEnv = n;
   endtask

   // Model: decides the expected outputs for the cycle that follows each edge.
   always @(posedge clk) begin
      logic abortNow;
`ifdef GENERADOR_PULSOS_ABORT_EN
      abortNow = abort_i;
`else
      abortNow = 1'b0;
`endif
      if (rst_i) begin
         q.delete();
         lastEnv = '0;
         expO = mk(1'b0, 1'b0, 1'b0, '0);
      end else if (!expO.ocup) begin
         if (start_i) begin
            buildTrain(num_pulsos_i, t_alto_i, t_bajo_i);
            expO = q.pop_front();
         end else begin
            expO = mk(1'b0, 1'b0, 1'b0, lastEnv);
         end
      end else if (abortNow && !expO.fin) begin
         q.delete();
         lastEnv = expO.env;
         expO = mk(1'b0, 1'b1, 1'b1, expO.env);
      end else if (q.size() > 0) begin
         expO = q.pop_front();
      end else begin
         expO = mk(1'b0, 1'b0, 1'b0, lastEnv);
      end
   end

   // Compare the DUT against the model on every cycle once reset has been seen.
   always @(negedge clk) begin
      obs_t d;
      if (checkEn) begin
         d = mk(pulso_o, ocupado_o, fin_o, enviados_o);
         vectors++;
         if (d !== expO) begin
            miscompares++;
            $display("[TB] FAIL cycleCheck t=%0t got p=%b o=%b f=%b n=%0d want p=%b o=%b f=%b n=%0d",
                     $time, d.pulso, d.ocup, d.fin, d.env, expO.pulso, expO.ocup, expO.fin, expO.env);
         end
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      vectors++;
      if (actual != expected) begin
         miscompares++;
         $display("[TB] FAIL %s got %0d want %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int n, input int ta, input int tb);
      @(negedge clk);
      start_i      = 1'b1;
      num_pulsos_i = N_W'(n);
      t_alto_i     = T_W'(ta);
      t_bajo_i     = T_W'(tb);
      @(negedge clk);
   endtask

   // Walks cycles 1..limit after acceptance; optional mid-train poke, reset and abort.
   task automatic observe(input int limit, input int pokeCycle, input int rstCycle, input int abortCycle,
                          output int finCycle, output int rises, output logic [63:0] pat,
                          output int finEnv, output int ocupAfter);
      logic prev;
      finCycle = -1; rises = 0; pat = '0; finEnv = -1; ocupAfter = -1; prev = 1'b0;
      for (int c = 1; c <= limit; c++) begin
         if (pulso_o && !prev) rises++;
         prev = pulso_o;
         if (c < 64) pat[c] = pulso_o;
         if (finCycle >= 0) begin
            ocupAfter = int'(ocupado_o);
            return;
         end
         if (rstCycle > 0 && c == rstCycle + 1) begin
            rst_i = 1'b0;
            return;
         end
         if (fin_o) begin
            finCycle = c;
            finEnv   = int'(enviados_o);
         end
         start_i = (c == pokeCycle);
         if (c == pokeCycle) begin
            num_pulsos_i = 8'd7;
            t_alto_i     = 16'd5;
         end
         rst_i   = (c == rstCycle);
         abort_i = (c == abortCycle);
         @(negedge clk);
      end
   endtask

   initial begin
      int fc, rs, fe, oa;
      logic [63:0] pat, want;

      rst_i = 1'b1;
      start_i = 1'b1;
      num_pulsos_i = 8'd3;
      repeat (3) @(negedge clk);
      checkEn = 1'b1;
      checkOutput("rstPulso", int'(pulso_o), 0);
      checkOutput("rstOcupado", int'(ocupado_o), 0);
      checkOutput("rstFin", int'(fin_o), 0);
      checkOutput("rstEnviados", int'(enviados_o), 0);
      rst_i = 1'b0;
      start_i = 1'b0;

      applyStimulus(3, 2, 3);
      checkOutput("modelQueue", q.size(), 15);
      observe(60, 0, 0, 0, fc, rs, pat, fe, oa);
      want = '0;
      for (int k = 0; k < 3; k++) begin
         want[5 * k + 1] = 1'b1;
         want[5 * k + 2] = 1'b1;
      end
      checkOutput("basicPattern", int'(pat[15:1] == want[15:1]), 1);
      checkOutput("basicFinCycle", fc, 16);
      checkOutput("basicRises", rs, 3);
      checkOutput("basicEnviados", fe, 3);
      checkOutput("basicOcupAfter", oa, 0);

      applyStimulus(0, 4, 4);
      observe(20, 0, 0, 0, fc, rs, pat, fe, oa);
      checkOutput("zeroFinCycle", fc, 2);
      checkOutput("zeroRises", rs, 0);
      checkOutput("zeroEnviados", fe, 0);

      applyStimulus(4, 0, 0);
      observe(30, 0, 0, 0, fc, rs, pat, fe, oa);
      checkOutput("zeroPhaseRises", rs, 4);
      checkOutput("zeroPhaseFin", fc, 9);
      checkOutput("zeroPhasePattern", int'(pat[8:1]), 8'b01010101);

      applyStimulus(3, 1, 1);
      observe(30, 2, 0, 0, fc, rs, pat, fe, oa);
      checkOutput("ignoreFin", fc, 7);
      checkOutput("ignoreRises", rs, 3);
      checkOutput("ignoreEnviados", fe, 3);

      applyStimulus(5, 2, 2);
      observe(30, 0, 5, 0, fc, rs, pat, fe, oa);
      checkOutput("resetNoFin", fc, -1);
      checkOutput("resetRises", rs, 2);
      checkOutput("resetPulso", int'(pulso_o), 0);
      checkOutput("resetOcupado", int'(ocupado_o), 0);
      checkOutput("resetEnviados", int'(enviados_o), 0);
      applyStimulus(2, 1, 2);
      observe(30, 0, 0, 0, fc, rs, pat, fe, oa);
      checkOutput("afterResetFin", fc, 7);
      checkOutput("afterResetRises", rs, 2);

`ifdef GENERADOR_PULSOS_ABORT_EN
      applyStimulus(10, 3, 2);
      observe(80, 0, 0, 12, fc, rs, pat, fe, oa);
      checkOutput("abortFin", fc, 13);
      checkOutput("abortEnviados", fe, 2);
      checkOutput("abortPulsoLow", int'(pat[13]), 0);
      checkOutput("abortRises", rs, 3);
`endif

      applyStimulus(255, 0, 0);
      observe(600, 0, 0, 0, fc, rs, pat, fe, oa);
      checkOutput("maxFin", fc, 511);
      checkOutput("maxEnviados", fe, 255);
      checkOutput("maxRises", rs, 255);

      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         start_i      = ($urandom_range(0, 5) == 0);
         num_pulsos_i = N_W'($urandom_range(0, 5));
         t_alto_i     = T_W'($urandom_range(0, 3));
         t_bajo_i     = T_W'($urandom_range(0, 3));
         rst_i        = ($urandom_range(0, 199) == 0);
         abort_i      = ($urandom_range(0, 39) == 0);
      end
      @(negedge clk);
      start_i = 1'b0;
      rst_i   = 1'b0;
      abort_i = 1'b0;
      repeat (40) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
